// File: rtl/topk_result_reader_pkg.sv
// Shared types and constants for the top-K result reader: FSM states, empty-slot marker,
// result beat layout and a small popcount helper.
package topk_result_reader_pkg;
  localparam int DATA_NUM    = 40;
  localparam int DATA_LENGTH = 14;
  localparam int OUT_NUM     = 4;
  localparam int NUM_WIDTH   = 6;
  localparam int TIMEOUT     = DATA_NUM + 8;
  localparam int RANK_W      = $clog2(OUT_NUM);
  localparam int CNT_W       = $clog2(OUT_NUM + 1);
  localparam int TCNT_W      = NUM_WIDTH + 2;

  localparam logic [DATA_LENGTH-1:0] SORT_EMPTY = '1;

  typedef enum logic [2:0] {IDLE, START, WAIT, OUT, DONE} state_t;

  typedef struct packed {
    logic [DATA_LENGTH-1:0] data;
    logic [NUM_WIDTH-1:0]   addr;
    logic [RANK_W-1:0]      rank;
    logic                   last;
  } beat_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [OUT_NUM-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < OUT_NUM; i++) c = c + CNT_W'(m[i]);
    return c;
  endfunction
endpackage

// File: rtl/topk_capture_buf.sv
// Holds one captured sorter result: per-slot data/addr, the set of slots still to send,
// and a lowest-index pick of the next slot to present.
module topk_capture_buf
  import topk_result_reader_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           capture,
  input  logic                           pop,
  input  logic                           clear_count,
  input  logic [OUT_NUM*DATA_LENGTH-1:0] sorted_data,
  input  logic [OUT_NUM*NUM_WIDTH-1:0]   sorted_addr,
  output logic [CNT_W-1:0]               capture_count,
  output logic [CNT_W-1:0]               result_count,
  output logic                           pick_valid,
  output beat_t                          pick
);
  logic [DATA_LENGTH-1:0] data_q [OUT_NUM];
  logic [NUM_WIDTH-1:0]   addr_q [OUT_NUM];
  logic [OUT_NUM-1:0]     pending;
  logic [OUT_NUM-1:0]     mask_in;
  logic [OUT_NUM-1:0]     rest;
  logic [RANK_W-1:0]      pick_idx;

  always_comb begin
    mask_in = '0;
    for (int i = 0; i < OUT_NUM; i++)
      mask_in[i] = (sorted_data[i*DATA_LENGTH +: DATA_LENGTH] != SORT_EMPTY);
  end

  assign capture_count = popcount(mask_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT_NUM; i++) begin
        data_q[i] <= SORT_EMPTY;
        addr_q[i] <= '0;
      end
      pending      <= '0;
      result_count <= '0;
    end else if (capture) begin
      for (int i = 0; i < OUT_NUM; i++) begin
        data_q[i] <= sorted_data[i*DATA_LENGTH +: DATA_LENGTH];
        addr_q[i] <= sorted_addr[i*NUM_WIDTH +: NUM_WIDTH];
      end
      pending      <= mask_in;
      result_count <= capture_count;
    end else begin
      if (pop && pick_valid) pending[pick_idx] <= 1'b0;
      if (clear_count) result_count <= '0;
    end
  end

  // Scanning downward leaves the lowest pending index as the pick.
  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int i = OUT_NUM - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pick_idx   = RANK_W'(i);
        pick_valid = 1'b1;
      end
    end
    rest           = pending;
    rest[pick_idx] = 1'b0;
    pick.data      = data_q[pick_idx];
    pick.addr      = addr_q[pick_idx];
    pick.rank      = pick_idx;
    pick.last      = (rest == '0);
  end
endmodule

// File: rtl/topk_result_reader.sv
// Initiator/consumer for the top-K sorter: starts a pass on request, captures the K smallest
// results on sort_finish and streams the non-empty slots out in rank order.
module topk_result_reader
  import topk_result_reader_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req,
  output logic                           busy,
  output logic                           sort_start,
  input  logic                           sort_finish,
  input  logic [OUT_NUM*DATA_LENGTH-1:0] sorted_data,
  input  logic [OUT_NUM*NUM_WIDTH-1:0]   sorted_addr,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_LENGTH-1:0]         out_data,
  output logic [NUM_WIDTH-1:0]           out_addr,
  output logic [RANK_W-1:0]              out_rank,
  output logic                           out_last,
  output logic                           done,
  output logic [CNT_W-1:0]               result_count,
  output logic                           timeout_err
);
  state_t            state, state_nxt;
  logic [TCNT_W-1:0] tcnt;
  logic              capture, to_hit, pick_valid;
  logic [CNT_W-1:0]  capture_count;
  beat_t             pick;

  topk_capture_buf u_buf (
    .clk           (clk),
    .rst           (rst),
    .capture       (capture),
    .pop           (out_valid & out_ready),
    .clear_count   (to_hit),
    .sorted_data   (sorted_data),
    .sorted_addr   (sorted_addr),
    .capture_count (capture_count),
    .result_count  (result_count),
    .pick_valid    (pick_valid),
    .pick          (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE:  if (req) state_nxt = START;
      START: state_nxt = WAIT;
      WAIT: begin
        // A finish in the last allowed cycle still wins over the timeout.
        if (sort_finish) begin
          capture   = 1'b1;
          state_nxt = (capture_count == '0) ? DONE : OUT;
        end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      OUT:   if (out_ready && pick.last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == START)
        tcnt <= '0;
      else if (state == WAIT && tcnt != '1)
        tcnt <= tcnt + 1'b1;
      if (state == IDLE && req)
        timeout_err <= 1'b0;
      else if (to_hit)
        timeout_err <= 1'b1;
    end
  end

  assign busy       = (state != IDLE);
  assign sort_start = (state == START);
  assign done       = (state == DONE);
  assign out_valid  = (state == OUT) && pick_valid;
  assign out_data   = out_valid ? pick.data : '0;
  assign out_addr   = out_valid ? pick.addr : '0;
  assign out_rank   = out_valid ? pick.rank : '0;
  assign out_last   = out_valid ? pick.last : 1'b0;
endmodule

// File: tb/tb_topk_result_reader.sv
// Self-checking bench for topk_result_reader: directed scenarios plus randomized queries
// checked against an expected-beat queue built from the slot contents.
module tb_topk_result_reader;
  localparam int DL = 14;
  localparam int AW = 6;
  localparam int K  = 4;
  localparam logic [DL-1:0] EMPTY = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          sort_finish = 1'b0;
  logic [K*DL-1:0] sorted_data = '0;
  logic [K*AW-1:0] sorted_addr = '0;
  logic          out_ready = 1'b0;
  logic          busy, sort_start, out_valid, out_last, done, timeout_err;
  logic [DL-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic [1:0]    out_rank;
  logic [2:0]    result_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DL-1:0] q_data [K];
  logic [AW-1:0] q_addr [K];

  typedef struct {
    logic [DL-1:0] d;
    logic [AW-1:0] a;
    int            r;
    bit            l;
  } exp_t;

  topk_result_reader dut (
    .clk(clk), .rst(rst), .req(req), .busy(busy), .sort_start(sort_start),
    .sort_finish(sort_finish), .sorted_data(sorted_data), .sorted_addr(sorted_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_rank(out_rank), .out_last(out_last), .done(done), .result_count(result_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set4(input logic [DL-1:0] d0, d1, d2, d3, input logic [AW-1:0] a0, a1, a2, a3);
    q_data[0] = d0; q_data[1] = d1; q_data[2] = d2; q_data[3] = d3;
    q_addr[0] = a0; q_addr[1] = a1; q_addr[2] = a2; q_addr[3] = a3;
  endtask

  task automatic drive_garbage();
    for (int i = 0; i < K; i++) begin
      sorted_data[i*DL +: DL] = DL'($urandom_range(0, 200));
      sorted_addr[i*AW +: AW] = AW'($urandom);
    end
  endtask

  // Request a query and deliver q_data/q_addr on the finish pulse after fin_delay WAIT cycles.
  task automatic start_and_finish(input int fin_delay, input bit stale);
    @(negedge clk);
    chk("idle_before_req", busy, 0);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("sort_start_pulse", sort_start, 1);
    chk("busy_in_start", busy, 1);
    if (stale) begin
      drive_garbage();
      sort_finish = 1'b1;
    end
    @(negedge clk);
    sort_finish = 1'b0;
    chk("sort_start_one_cycle", sort_start, 0);
    repeat (fin_delay) @(negedge clk);
    for (int i = 0; i < K; i++) begin
      sorted_data[i*DL +: DL] = q_data[i];
      sorted_addr[i*AW +: AW] = q_addr[i];
    end
    sort_finish = 1'b1;
    @(negedge clk);
    sort_finish = 1'b0;
    drive_garbage();
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic collect(input int mode);
    exp_t exp_q[$];
    exp_t e;
    int   beat, ndone, cyc;
    bit   seen_done, rdy;
    beat = 0; ndone = 0; cyc = 0; seen_done = 0;
    for (int i = 0; i < K; i++) begin
      if (q_data[i] != EMPTY) begin
        e.d = q_data[i]; e.a = q_addr[i]; e.r = i; e.l = 0;
        exp_q.push_back(e);
      end
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].l = 1;
    chk("first_beat_latency", out_valid, exp_q.size() != 0);
    chk("empty_done_now", done, exp_q.size() == 0);
    while (cyc < 200) begin
      if (done) begin
        ndone++;
        seen_done = 1;
      end else if (seen_done && !busy) begin
        break;
      end
      case (mode)
        0: rdy = 1;
        1: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom);
      endcase
      out_ready = rdy;
      if (out_valid) begin
        if (beat < exp_q.size()) begin
          chk("beat_data", out_data, exp_q[beat].d);
          chk("beat_addr", out_addr, exp_q[beat].a);
          chk("beat_rank", out_rank, exp_q[beat].r);
          chk("beat_last", out_last, exp_q[beat].l);
        end else begin
          chk("extra_beat", out_valid, 0);
        end
        if (seen_done) chk("valid_after_done", out_valid, 0);
        if (rdy) beat++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk("within_budget", cyc < 200, 1);
    chk("beat_total", beat, exp_q.size());
    chk("done_pulses", ndone, 1);
    chk("result_count", result_count, exp_q.size());
    chk("no_timeout_err", timeout_err, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [2:0] held;
    // Reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_sort_start", sort_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_count", result_count, 0);
    chk("rst_timeout_err", timeout_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Full result
    set4(3, 7, 9, 12, 5, 1, 30, 2);
    start_and_finish(3, 0);
    collect(0);

    // Partial result, then all-empty result
    set4(4, 9, EMPTY, EMPTY, 11, 22, 33, 44);
    start_and_finish(0, 0);
    collect(0);
    set4(EMPTY, EMPTY, EMPTY, EMPTY, 1, 2, 3, 4);
    start_and_finish(5, 0);
    collect(0);

    // Backpressure, including a hole in the middle of the ranks
    set4(10, 20, 30, 40, 7, 8, 9, 10);
    start_and_finish(2, 0);
    collect(1);
    set4(1, EMPTY, 5, 6, 3, 4, 5, 6);
    start_and_finish(1, 0);
    collect(1);

    // Finish pulse while idle is ignored
    held = result_count;
    drive_garbage();
    sort_finish = 1'b1;
    @(negedge clk);
    sort_finish = 1'b0;
    chk("idle_finish_busy", busy, 0);
    chk("idle_finish_valid", out_valid, 0);
    chk("idle_finish_count", result_count, held);

    // Finish in the START cycle is stale
    set4(2, 4, 6, EMPTY, 40, 41, 42, 43);
    start_and_finish(4, 1);
    collect(0);

    // Timeout
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("to_sort_start", sort_start, 1);
    cyc = 0;
    while (cyc < 100 && !done) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_wait_cycles", cyc - 1, 48);
    chk("to_done", done, 1);
    chk("to_err_set", timeout_err, 1);
    chk("to_count", result_count, 0);
    chk("to_no_valid", out_valid, 0);
    @(negedge clk);
    chk("to_idle", busy, 0);
    chk("to_err_sticky", timeout_err, 1);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("to_err_cleared", timeout_err, 0);
    set4(8, 9, EMPTY, EMPTY, 1, 2, 3, 4);
    @(negedge clk);
    for (int i = 0; i < K; i++) begin
      sorted_data[i*DL +: DL] = q_data[i];
      sorted_addr[i*AW +: AW] = q_addr[i];
    end
    sort_finish = 1'b1;
    @(negedge clk);
    sort_finish = 1'b0;
    collect(0);

    // Reset mid-stream
    set4(3, 7, 9, 12, 5, 1, 30, 2);
    start_and_finish(1, 0);
    chk("mid_beat0_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_beat1_rank", out_rank, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    set4(100, 200, 300, EMPTY, 9, 8, 7, 6);
    start_and_finish(2, 0);
    collect(2);

    // Randomized queries
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < K; i++) begin
        q_data[i] = ($urandom_range(0, 2) == 0) ? EMPTY : DL'($urandom_range(0, 16382));
        q_addr[i] = AW'($urandom);
      end
      start_and_finish(int'($urandom_range(0, 12)), 1'($urandom));
      collect(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
